// File: rtl/mmind_input_cond.sv
// mmind_input_cond: board input conditioning in front of mmind.
// Two pushbuttons are synchronised, debounced by independent 4-state FSMs and
// turned into single-cycle press pulses. setans_btn and guess_btn are never
// high together; a coincident guess press is deferred by one cycle.
// The slide switches get a 2-flop synchroniser when MMIND_SW_SYNC_EN is
// defined, otherwise a single register stage.
//
// Debounce FSM (one per button)
//   state        | meaning
//   IDLE         | button released and stable
//   PRESS_WAIT   | sync high, counting stable-high cycles
//   HELD         | press accepted, event already issued
//   RELEASE_WAIT | sync low, counting stable-low cycles
module mmind_input_cond #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       setans_raw,
    input  logic       guess_raw,
    input  logic [7:0] switches_raw,
    output logic       setans_btn,
    output logic       guess_btn,
    output logic [7:0] switches
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // bit 0 = set-answer button, bit 1 = guess button
    logic [1:0]            btn_meta_q;
    logic [1:0]            btn_sync_q;
    logic [1:0][1:0]       state_q, state_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            event_d;

    logic setans_btn_q, setans_btn_d;
    logic guess_btn_q, guess_btn_d;
    logic guess_pend_q, guess_pend_d;
    logic guess_want;

    // Two-flop synchroniser for both buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 2'b00;
            btn_sync_q <= 2'b00;
        end else begin
            btn_meta_q <= {guess_raw, setans_raw};
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce next-state logic; every counting state exits at CNT_LAST so cnt never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        event_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            case (state_q[b])
                ST_IDLE: begin
                    if (btn_sync_q[b]) begin
                        state_d[b] = ST_PRESS_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_sync_q[b]) begin
                        state_d[b] = ST_IDLE;
                        cnt_d[b]   = '0;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = ST_HELD;
                        event_d[b] = 1'b1;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!btn_sync_q[b]) begin
                        state_d[b] = ST_RELEASE_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                default: begin
                    // a high blip while releasing is bounce: back to HELD, no event
                    if (btn_sync_q[b]) begin
                        state_d[b] = ST_HELD;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = ST_IDLE;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
            endcase
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= {ST_IDLE, ST_IDLE};
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration: set-answer wins a tie, the guess is held for exactly one cycle
    always_comb begin
        guess_want   = event_d[1] | guess_pend_q;
        setans_btn_d = event_d[0];
        guess_btn_d  = guess_want & ~event_d[0];
        guess_pend_d = guess_want & event_d[0];
    end

    // Registered pulse outputs and pending-guess flag
    always_ff @(posedge clk) begin
        if (reset) begin
            setans_btn_q <= 1'b0;
            guess_btn_q  <= 1'b0;
            guess_pend_q <= 1'b0;
        end else begin
            setans_btn_q <= setans_btn_d;
            guess_btn_q  <= guess_btn_d;
            guess_pend_q <= guess_pend_d;
        end
    end

    assign setans_btn = setans_btn_q;
    assign guess_btn  = guess_btn_q;

`ifdef MMIND_SW_SYNC_EN
    logic [7:0] sw_meta_q;
    logic [7:0] sw_q;

    // Two-flop synchroniser on the slide switches
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= 8'h00;
            sw_q      <= 8'h00;
        end else begin
            sw_meta_q <= switches_raw;
            sw_q      <= sw_meta_q;
        end
    end
`else
    logic [7:0] sw_q;

    // Single register stage; only safe for quasi-static switches
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q <= 8'h00;
        end else begin
            sw_q <= switches_raw;
        end
    end
`endif

    assign switches = sw_q;

endmodule

// File: tb/tb_mmind_input_cond.sv
// Directed bench for mmind_input_cond with DB_CYCLES=4.
// Cycle index 0 is the first rising edge that samples a new raw value.
module tb_mmind_input_cond;

    localparam int DB = 4;
`ifdef MMIND_SW_SYNC_EN
    localparam int SW_LAT = 1;
`else
    localparam int SW_LAT = 0;
`endif

    logic       clk;
    logic       reset;
    logic       setans_raw;
    logic       guess_raw;
    logic [7:0] switches_raw;
    logic       setans_btn;
    logic       guess_btn;
    logic [7:0] switches;

    mmind_input_cond #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .setans_raw   (setans_raw),
        .guess_raw    (guess_raw),
        .switches_raw (switches_raw),
        .setans_btn   (setans_btn),
        .guess_btn    (guess_btn),
        .switches     (switches)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc_idx, set_cnt, guess_cnt, set_first, guess_first, set_last, guess_last;
    int both_cnt, consec_cnt, out_nz;
    logic prev_set, prev_guess;
    logic [7:0] sw_hist [0:31];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc_idx     = -1;
        set_cnt     = 0;
        guess_cnt   = 0;
        set_first   = -1;
        guess_first = -1;
        set_last    = -1;
        guess_last  = -1;
        both_cnt    = 0;
        consec_cnt  = 0;
        out_nz      = 0;
        prev_set    = 1'b0;
        prev_guess  = 1'b0;
    endtask

    // advance one edge and record what the outputs did just after it
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_idx++;
        if (setans_btn !== 1'b0 || guess_btn !== 1'b0) out_nz++;
        if (setans_btn === 1'b1) begin
            set_cnt++;
            if (set_first < 0) set_first = cyc_idx;
            set_last = cyc_idx;
            if (prev_set) consec_cnt++;
        end
        if (guess_btn === 1'b1) begin
            guess_cnt++;
            if (guess_first < 0) guess_first = cyc_idx;
            guess_last = cyc_idx;
            if (prev_guess) consec_cnt++;
        end
        if (setans_btn === 1'b1 && guess_btn === 1'b1) both_cnt++;
        prev_set   = (setans_btn === 1'b1);
        prev_guess = (guess_btn === 1'b1);
        if (cyc_idx >= 0 && cyc_idx < 32) sw_hist[cyc_idx] = switches;
    endtask

    initial begin
        int sw_nz;
        logic [4:0] bounce;

        reset        = 1'b1;
        setans_raw   = 1'b0;
        guess_raw    = 1'b0;
        switches_raw = 8'h00;
        clear_stats();
        cyc();
        cyc();

        // reset held with toggling inputs
        clear_stats();
        sw_nz = 0;
        for (int i = 0; i < 10; i++) begin
            setans_raw   = i[0];
            guess_raw    = ~i[0];
            switches_raw = 8'(i * 37 + 5);
            cyc();
            if (switches !== 8'h00) sw_nz++;
        end
        check_val("rst_pulses", out_nz, 0);
        check_val("rst_sw_nonzero", sw_nz, 0);
        check_val("rst_sw_val", int'(switches), 0);
        reset        = 1'b0;
        setans_raw   = 1'b0;
        guess_raw    = 1'b0;
        switches_raw = 8'h00;
        repeat (12) cyc();

        // clean set-answer press
        clear_stats();
        setans_raw = 1'b1;
        repeat (20) cyc();
        setans_raw = 1'b0;
        repeat (12) cyc();
        check_val("set_count", set_cnt, 1);
        check_val("set_latency", set_first, DB + 2);
        check_val("set_no_guess", guess_cnt, 0);
        check_val("set_width", consec_cnt, 0);

        // bounced guess press, then held
        clear_stats();
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            guess_raw = bounce[i];
            cyc();
        end
        guess_raw = 1'b1;
        repeat (10) cyc();
        guess_raw = 1'b0;
        repeat (12) cyc();
        check_val("bounce_count", guess_cnt, 1);
        check_val("bounce_latency", guess_first, 11);
        check_val("bounce_no_set", set_cnt, 0);

        // coincident presses
        clear_stats();
        setans_raw = 1'b1;
        guess_raw  = 1'b1;
        repeat (10) cyc();
        setans_raw = 1'b0;
        guess_raw  = 1'b0;
        repeat (12) cyc();
        check_val("tie_set_count", set_cnt, 1);
        check_val("tie_guess_count", guess_cnt, 1);
        check_val("tie_set_cycle", set_first, DB + 2);
        check_val("tie_guess_cycle", guess_first, DB + 3);
        check_val("tie_overlap", both_cnt, 0);

        // switch synchroniser latency
        clear_stats();
        check_val("sw_before", int'(switches), 0);
        switches_raw = 8'hc3;
        repeat (3) cyc();
        switches_raw = 8'hff;
        repeat (4) cyc();
        check_val("sw_c3_first", int'(sw_hist[SW_LAT]), 8'hc3);
        check_val("sw_c3_hold", int'(sw_hist[SW_LAT + 2]), 8'hc3);
        check_val("sw_ff", int'(sw_hist[SW_LAT + 3]), 8'hff);
        switches_raw = 8'h00;
        repeat (3) cyc();

        // reset while guess is HELD
        clear_stats();
        guess_raw = 1'b1;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        check_val("held_rst_low", int'(guess_btn), 0);
        reset = 1'b0;
        repeat (12) cyc();
        guess_raw = 1'b0;
        repeat (12) cyc();
        check_val("held_rst_count", guess_cnt, 2);
        check_val("held_rst_first", guess_first, DB + 2);
        check_val("held_rst_repress", guess_last, 17);

        // reset discards a pending guess
        clear_stats();
        setans_raw = 1'b1;
        guess_raw  = 1'b1;
        repeat (7) cyc();
        reset = 1'b1;
        cyc();
        check_val("pend_rst_low", int'(guess_btn), 0);
        reset = 1'b0;
        repeat (12) cyc();
        setans_raw = 1'b0;
        guess_raw  = 1'b0;
        repeat (12) cyc();
        check_val("pend_set_count", set_cnt, 2);
        check_val("pend_set_last", set_last, 14);
        check_val("pend_guess_count", guess_cnt, 1);
        check_val("pend_guess_cycle", guess_first, 15);
        check_val("pend_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
